// File: rtl/analog_mux_sequencer.sv
`default_nettype none
// ============================================================================
// analog_mux_sequencer : break-before-make hold/scan sequencer for analog switches
// Revision 1.0
// ============================================================================
module analog_mux_sequencer #(
  parameter int NCH         = 8,
  parameter int DWELL_W     = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [2:0]         sel_ch,
  input  logic [DWELL_W-1:0] dwell,
  output logic [NCH-1:0]     sw_en,
  output logic [2:0]         ch_idx,
  output logic               busy,
  output logic               sample_strobe,
  output logic               done
);

  localparam int              CNT_W       = (DWELL_W > 4) ? DWELL_W : 4;
  localparam logic [1:0]      MODE_HOLD   = 2'b00;
  localparam logic [1:0]      MODE_SINGLE = 2'b01;
  localparam logic [1:0]      MODE_RSVD   = 2'b11;
  localparam logic [2:0]      LAST_CH     = 3'(NCH - 1);
  localparam logic [CNT_W-1:0] DEAD_RELOAD = CNT_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    DWELL = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [2:0]           ch_n;
  logic [1:0]           mode_q, mode_n;
  logic [DWELL_W-1:0]   dwell_q, dwell_n;   // dwell reload value (dwell-1, zero treated as one)
  logic [NCH-1:0]       sw_n;
  logic                 busy_n, strobe_n, done_n;
  logic [2:0]           sel_clamped;

  assign sel_clamped = ({1'b0, sel_ch} >= 4'(NCH)) ? LAST_CH : sel_ch;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ch_n    = ch_idx;
    mode_n  = mode_q;
    dwell_n = dwell_q;
    done_n  = 1'b0;
    if (!ena) begin
      state_n = IDLE;
      cnt_n   = '0;
      ch_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop && (mode != MODE_RSVD)) begin
            mode_n  = mode;
            dwell_n = (dwell == '0) ? '0 : dwell - 1'b1;
            ch_n    = (mode == MODE_HOLD) ? sel_clamped : 3'd0;
            cnt_n   = DEAD_RELOAD;
            state_n = DEAD;
          end
        end
        DEAD: begin
          if (stop) begin
            state_n = DRAIN;
            cnt_n   = DEAD_RELOAD;
          end else if (cnt == '0) begin
            state_n = DWELL;
            cnt_n   = CNT_W'(dwell_q);
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        DWELL: begin
          if (stop) begin
            state_n = DRAIN;
            cnt_n   = DEAD_RELOAD;
          end else if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (mode_q == MODE_HOLD) begin
            // hold re-arms the dwell on the same channel without opening the switch
            cnt_n = CNT_W'(dwell_q);
          end else if (ch_idx != LAST_CH) begin
            ch_n    = ch_idx + 1'b1;
            cnt_n   = DEAD_RELOAD;
            state_n = DEAD;
          end else if (mode_q == MODE_SINGLE) begin
            ch_n    = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            ch_n    = '0;
            cnt_n   = DEAD_RELOAD;
            state_n = DEAD;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            ch_n    = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // outputs are computed from the next state so they can be registered
    busy_n   = (state_n != IDLE);
    strobe_n = (state_n == DWELL) && (cnt_n == '0);
    for (int i = 0; i < NCH; i++) begin
      sw_n[i] = (state_n == DWELL) && (ch_n == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      ch_idx        <= '0;
      mode_q        <= '0;
      dwell_q       <= '0;
      sw_en         <= '0;
      busy          <= 1'b0;
      sample_strobe <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ch_idx        <= ch_n;
      mode_q        <= mode_n;
      dwell_q       <= dwell_n;
      sw_en         <= sw_n;
      busy          <= busy_n;
      sample_strobe <= strobe_n;
      done          <= done_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_analog_mux_sequencer.sv
`default_nettype none
// ============================================================================
// tb_analog_mux_sequencer : three sequencers (NCH 8/4/2) against a schedule model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_analog_mux_sequencer;

  localparam int DEAD = 2;

  typedef struct packed {
    logic [7:0] sw;
    logic [2:0] ch;
    logic       busy;
    logic       stb;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, ena, start, stop;
  logic [1:0] mode;
  logic [2:0] sel_ch;
  logic [7:0] dwell;

  logic [7:0] sw8;
  logic [3:0] sw4;
  logic [1:0] sw2;
  logic [7:0] sw_o   [3];
  logic [2:0] ch_o   [3];
  logic       busy_o [3];
  logic       stb_o  [3];
  logic       done_o [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  analog_mux_sequencer #(.NCH(8), .DWELL_W(8), .DEAD_CYCLES(DEAD)) dut8 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .mode(mode),
    .sel_ch(sel_ch), .dwell(dwell), .sw_en(sw8), .ch_idx(ch_o[0]), .busy(busy_o[0]),
    .sample_strobe(stb_o[0]), .done(done_o[0]));
  analog_mux_sequencer #(.NCH(4), .DWELL_W(8), .DEAD_CYCLES(DEAD)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .mode(mode),
    .sel_ch(sel_ch), .dwell(dwell), .sw_en(sw4), .ch_idx(ch_o[1]), .busy(busy_o[1]),
    .sample_strobe(stb_o[1]), .done(done_o[1]));
  analog_mux_sequencer #(.NCH(2), .DWELL_W(8), .DEAD_CYCLES(DEAD)) dut2 (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .mode(mode),
    .sel_ch(sel_ch), .dwell(dwell), .sw_en(sw2), .ch_idx(ch_o[2]), .busy(busy_o[2]),
    .sample_strobe(stb_o[2]), .done(done_o[2]));

  assign sw_o[0] = sw8;
  assign sw_o[1] = {4'b0, sw4};
  assign sw_o[2] = {6'b0, sw2};

  // ---------------- schedule model: queue of future output cycles ----------------
  exp_t cur [3];
  exp_t mq  [3][$];
  bit   draining [3];
  bit   ended    [3];
  bit   first    [3];
  int   lm [3], ld [3], lch [3];

  function automatic int nch_of(int i);
    return (i == 0) ? 8 : (i == 1) ? 4 : 2;
  endfunction

  function automatic exp_t mk(int sw, int ch, bit b, bit s, bit d);
    exp_t e;
    e.sw = 8'(sw); e.ch = 3'(ch); e.busy = b; e.stb = s; e.done = d;
    return e;
  endfunction

  task automatic push_dead(int i, int ch);
    for (int k = 0; k < DEAD; k++) mq[i].push_back(mk(0, ch, 1, 0, 0));
  endtask

  task automatic push_dwell(int i, int ch);
    for (int k = 0; k < ld[i]; k++) mq[i].push_back(mk(1 << ch, ch, 1, k == ld[i] - 1, 0));
  endtask

  task automatic extend(int i);
    if (lm[i] == 0) begin
      if (first[i]) push_dead(i, lch[i]);
      first[i] = 0;
      push_dwell(i, lch[i]);
    end else begin
      push_dead(i, lch[i]);
      push_dwell(i, lch[i]);
      if (lch[i] == nch_of(i) - 1) begin
        if (lm[i] == 1) begin
          mq[i].push_back(mk(0, 0, 0, 0, 1));
          ended[i] = 1;
        end else lch[i] = 0;
      end else lch[i] = lch[i] + 1;
    end
  endtask

  task automatic model_step(int i);
    if (!ena) begin
      mq[i].delete();
      ended[i] = 1;
    end else if (cur[i].busy && !draining[i] && stop) begin
      mq[i].delete();
      push_dead(i, int'(cur[i].ch));
      mq[i].push_back(mk(0, 0, 0, 0, 1));
      draining[i] = 1;
      ended[i]    = 1;
    end else if (!cur[i].busy && start && !stop && mode != 2'b11) begin
      mq[i].delete();
      lm[i]       = int'(mode);
      ld[i]       = (dwell == 0) ? 1 : int'(dwell);
      lch[i]      = (mode != 2'b00) ? 0 : (int'(sel_ch) >= nch_of(i)) ? nch_of(i) - 1 : int'(sel_ch);
      first[i]    = 1;
      ended[i]    = 0;
      draining[i] = 0;
    end
    if (mq[i].size() == 0 && !ended[i]) extend(i);
    if (mq[i].size() > 0) cur[i] = mq[i].pop_front();
    else cur[i] = mk(0, 0, 0, 0, 0);
  endtask

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i].delete();
        cur[i]      = mk(0, 0, 0, 0, 0);
        draining[i] = 0;
        ended[i]    = 1;
      end else model_step(i);
    end
  end

  // ---------------- per-cycle compare plus switch-safety checker ----------------
  logic [7:0] last_sw  [3] = '{default: 8'h0};
  int         zero_run [3] = '{default: 0};

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sw_o[i], ch_o[i], busy_o[i], stb_o[i], done_o[i]} !== cur[i]) begin
        errors++;
        $display("FAIL model_cmp inst%0d t=%0t: got sw=%h ch=%0d busy=%b stb=%b done=%b, expected sw=%h ch=%0d busy=%b stb=%b done=%b",
                 i, $time, sw_o[i], ch_o[i], busy_o[i], stb_o[i], done_o[i],
                 cur[i].sw, cur[i].ch, cur[i].busy, cur[i].stb, cur[i].done);
      end
      checks++;
      if (!$onehot0(sw_o[i])) begin
        errors++;
        $display("FAIL onehot inst%0d t=%0t: got sw=%h, expected at most one bit", i, $time, sw_o[i]);
      end
      if (sw_o[i] != 8'h0) begin
        if (last_sw[i] != 8'h0 && sw_o[i] != last_sw[i]) begin
          checks++;
          if (zero_run[i] < DEAD) begin
            errors++;
            $display("FAIL break_before_make inst%0d t=%0t: got gap=%0d, expected >= %0d", i, $time, zero_run[i], DEAD);
          end
        end
        last_sw[i]  <= sw_o[i];
        zero_run[i] <= 0;
      end else zero_run[i] <= zero_run[i] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] d, input logic [2:0] s);
    mode = m; dwell = d; sel_ch = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- directed scenarios followed by random traffic ----------------
  initial begin
    int busy_cnt, stb_cnt, done_cyc;
    logic [1:0] seq [6];
    seq = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; sel_ch = 3'd0; dwell = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_sw8", sw8, 0);
    check("reset_busy8", busy_o[0], 0);
    check("reset_ch8", ch_o[0], 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single scan, dwell 3: 40 busy cycles, done in cycle 41
    launch(2'b01, 8'd3, 3'd0);
    busy_cnt = 0; stb_cnt = 0; done_cyc = 0;
    for (int k = 1; k <= 45; k++) begin
      if (busy_o[0]) busy_cnt++;
      if (stb_o[0]) stb_cnt++;
      if (done_o[0]) done_cyc = k;
      if (k == 3)  begin check("scan_c3_sw8", sw8, 8'h01); check("model_c3_sw8", cur[0].sw, 8'h01); end
      if (k == 38) check("scan_c38_sw8", sw8, 8'h80);
      @(negedge clk);
    end
    check("scan_busy_cycles", busy_cnt, 40);
    check("scan_strobes", stb_cnt, 8);
    check("scan_done_cycle", done_cyc, 41);

    // hold with clamp; mid-operation input changes must be ignored
    launch(2'b00, 8'd0, 3'd6);
    for (int k = 2; k <= 10; k++) begin
      start = 1'($urandom); mode = 2'($urandom); dwell = 8'($urandom); sel_ch = 3'($urandom);
      if (k == 8) begin
        check("hold_sw4", sw4, 4'h8);
        check("hold_stb4", stb_o[1], 1);
        check("hold_sw8", sw8, 8'h40);
        check("model_hold_sw4", cur[1].sw, 8'h08);
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("hold_drain1_sw4", sw4, 0);
    check("hold_drain1_busy4", busy_o[1], 1);
    @(negedge clk);
    @(negedge clk);
    check("hold_done4", done_o[1], 1);
    check("hold_idle_busy4", busy_o[1], 0);
    repeat (2) @(negedge clk);

    // continuous wrap on NCH=2, then long soak under input noise
    launch(2'b10, 8'd1, 3'd0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("cont_seq%0d_sw2", k), sw2, seq[k]);
      @(negedge clk);
    end
    for (int k = 0; k < 1000; k++) begin
      start = 1'($urandom); mode = 2'($urandom); dwell = 8'($urandom); sel_ch = 3'($urandom);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (4) @(negedge clk);

    // abort in second dwell cycle of channel 3, then start+stop in IDLE
    launch(2'b01, 8'd3, 3'd0);
    repeat (17) @(negedge clk);
    check("abort_c18_sw8", sw8, 8'h08);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_sw8", sw8, 0);
    check("abort_busy8", busy_o[0], 1);
    repeat (2) @(negedge clk);
    check("abort_done8", done_o[0], 1);
    start = 1'b1; stop = 1'b1; mode = 2'b01;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy8", busy_o[0], 0);
    check("startstop_busy2", busy_o[2], 0);

    // asynchronous reset during dwell, then reserved-mode start
    launch(2'b01, 8'd3, 3'd0);
    repeat (3) @(negedge clk);
    check("areset_pre_sw8", sw8, 8'h01);
    #2 rst = 1'b1;
    #1 check("areset_sw8", sw8, 0);
    check("areset_sw2", sw2, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(2'b11, 8'd3, 3'd0);
    check("rsvd_busy8", busy_o[0], 0);
    @(negedge clk);
    check("rsvd_busy4", busy_o[1], 0);

    // ena drop during DEAD
    launch(2'b01, 8'd3, 3'd0);
    check("ena_pre_busy8", busy_o[0], 1);
    ena = 1'b0;
    @(negedge clk);
    check("ena_busy8", busy_o[0], 0);
    check("ena_done8", done_o[0], 0);
    ena = 1'b1;
    @(negedge clk);
    check("ena_done8_later", done_o[0], 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      ena    = ($urandom_range(0, 49) != 0);
      start  = ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 29) == 0);
      mode   = 2'($urandom);
      sel_ch = 3'($urandom);
      dwell  = 8'($urandom_range(0, 4));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/analog_mux_sequencer.md
ANALOG_MUX_SEQUENCER -- requirements
Module: analog_mux_sequencer

Interface
REQ-001 The block SHALL have parameter NCH, default 8, meaning the number of analog switch channels (legal 2..8).
REQ-002 The block SHALL have parameter DWELL_W, default 8, meaning the width of the dwell-time operand.
REQ-003 The block SHALL have parameter DEAD_CYCLES, default 2, meaning the all-off break-before-make gap in clocks (legal 1..15).
REQ-004 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port ena, input, 1 bit: block enable; low forces idle.
REQ-007 Port start, input, 1 bit: launch request, sampled in IDLE only.
REQ-008 Port stop, input, 1 bit: abort request, honoured in any non-IDLE state.
REQ-009 Port mode, input, 2 bits: 00 hold, 01 single scan, 10 continuous scan, 11 reserved.
REQ-010 Port sel_ch, input, 3 bits: channel used in hold mode.
REQ-011 Port dwell, input, DWELL_W bits: enabled cycles per channel.
REQ-012 Port sw_en, output, NCH bits: one-hot analog switch enables.
REQ-013 Port ch_idx, output, 3 bits: index of the active or next channel.
REQ-014 Port busy, output, 1 bit: high in every state except IDLE.
REQ-015 Port sample_strobe, output, 1 bit: one-cycle pulse marking a settled channel.
REQ-016 Port done, output, 1 bit: one-cycle pulse at single-scan completion or at abort completion.

Function
REQ-017 States SHALL be IDLE, DEAD, DWELL, DRAIN.
REQ-018 In IDLE with ena=1, start=1, stop=0 and mode!=11, the block SHALL latch mode, dwell and sel_ch and enter DEAD on that edge.
REQ-019 A latched dwell of 0 SHALL be treated as 1.
REQ-020 A latched sel_ch >= NCH SHALL be clamped to NCH-1.
REQ-021 A start with mode=11 SHALL be ignored, with the block remaining in IDLE.
REQ-022 Start SHALL be ignored outside IDLE, and mode, dwell and sel_ch SHALL NOT be re-sampled mid-operation.
REQ-023 ch_idx on entry to DEAD SHALL be sel_ch in hold mode and 0 in the scan modes.
REQ-024 DEAD SHALL last exactly DEAD_CYCLES cycles with sw_en=0, then enter DWELL.
REQ-025 DWELL SHALL drive sw_en = 1<<ch_idx for exactly dwell cycles.
REQ-026 sample_strobe SHALL be high only in the last DWELL cycle of each channel visit.
REQ-027 At DWELL expiry in hold mode, the block SHALL restart the dwell count on the same channel with no DEAD gap, so sw_en stays on and sample_strobe recurs every dwell cycles.
REQ-028 At DWELL expiry in the scan modes with ch_idx<NCH-1, ch_idx SHALL increment and the block SHALL enter DEAD.
REQ-029 At DWELL expiry with ch_idx=NCH-1 in single-scan mode, the block SHALL enter IDLE and assert done for that next cycle.
REQ-030 At DWELL expiry with ch_idx=NCH-1 in continuous mode, ch_idx SHALL wrap to 0 and the block SHALL enter DEAD.
REQ-031 stop=1 in DEAD or DWELL SHALL force sw_en=0 on the next edge and enter DRAIN.
REQ-032 DRAIN SHALL hold sw_en=0 for DEAD_CYCLES cycles, then enter IDLE with a one-cycle done pulse.
REQ-033 When start and stop are both high in IDLE, stop SHALL win and start SHALL be ignored.
REQ-034 ena=0 SHALL synchronously force IDLE, sw_en=0 and ch_idx=0 on the next edge, with no done pulse.
REQ-035 At most one bit of sw_en SHALL be high in any cycle.
REQ-036 sw_en SHALL be 0 for at least DEAD_CYCLES cycles between any two different one-hot values.
REQ-037 All outputs SHALL be registered.

Reset
REQ-038 While rst=1 the block SHALL be in IDLE with sw_en=0, ch_idx=0, busy=0, sample_strobe=0, done=0 and all counters 0, independent of clk.
REQ-039 On rst deassertion the block SHALL wait in IDLE for start.
REQ-040 Reset asserted mid-scan SHALL clear sw_en immediately, without waiting for a clock edge.

Verification
REQ-041 Single scan: NCH=8, DEAD_CYCLES=2, dwell=3, mode=01, start at edge E0 -> busy for 40 cycles, sw_en stepping 0x01..0x80, 8 strobes, done at cycle 41, then IDLE.
REQ-042 Hold with clamp: NCH=4, sel_ch=6, dwell=0 -> after 2 dead cycles sw_en=0x8 steadily, sample_strobe every cycle; stop -> 2 cycles of sw_en=0, then done, then IDLE.
REQ-043 Continuous wrap: NCH=2, dwell=1 -> sw_en repeats 0,0,01,0,0,10; a checker confirms REQ-035 and REQ-036 hold for 1000 cycles.
REQ-044 Abort and priority: stop in the 2nd DWELL cycle of ch 3 -> next cycle sw_en=0 and DRAIN; start+stop together in IDLE -> busy stays 0.
REQ-045 Asynchronous reset: assert rst between clock edges during DWELL -> sw_en=0 before the next edge; after release, a start with mode=11 -> no state change.
REQ-046 ena drop: ena=0 during DEAD -> IDLE with sw_en=0 and no done pulse.
